// File: rtl/gnr_attractor_ctrl_pkg.sv
// Shared types for the attractor search controller: FSM state encoding and default sizes.
package gnr_ctrl_pkg;

    localparam int GNR_N_NODES_DEF = 8;
    localparam int GNR_CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STEP   = 3'd2,
        CHECK  = 3'd3,
        PSTEP  = 3'd4,
        PCHECK = 3'd5,
        OUT    = 3'd6
    } state_e;

endpackage

// File: rtl/gnr_attractor_ctrl.sv
// Tortoise/hare attractor search over a bank of dual-copy Boolean-network nodes.
// Sweeps a range of initial states and streams one period/steps result per state.
module gnr_attractor_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int N_NODES = GNR_N_NODES_DEF,
    parameter int CNT_W   = GNR_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_base,
    input  logic [CNT_W-1:0]   num_inits,
    input  logic [CNT_W-1:0]   max_steps,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [N_NODES-1:0] res_state,
    output logic [CNT_W-1:0]   res_period,
    output logic [CNT_W-1:0]   res_steps,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);

    typedef struct packed {
        logic [N_NODES-1:0] init;
        logic [N_NODES-1:0] state;
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   steps;
        logic               timeout;
    } result_t;

    state_e             state_q, state_d;
    logic [N_NODES-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [CNT_W-1:0]   per_q, per_d;
    result_t            res_q, res_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            left_q  <= '0;
            max_q   <= '0;
            steps_q <= '0;
            per_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            left_q  <= left_d;
            max_q   <= max_d;
            steps_q <= steps_d;
            per_q   <= per_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        left_d     = left_q;
        max_d      = max_q;
        steps_d    = steps_q;
        per_d      = per_q;
        res_d      = res_q;
        done_d     = 1'b0;
        reset_nos  = 1'b0;
        start_s0   = 1'b0;
        start_s1   = 1'b0;
        init_state = '0;
        res_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d  = init_base;
                    left_d = num_inits;
                    // A zero budget still runs one step so the search always terminates.
                    max_d  = (max_steps == '0) ? CNT_W'(1) : max_steps;
                    if (num_inits == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                reset_nos  = 1'b1;
                init_state = cur_q;
                steps_d    = '0;
                per_d      = '0;
                res_d      = '0;
                res_d.init = cur_q;
                state_d    = STEP;
            end
            STEP: begin
                start_s0 = 1'b1;
                start_s1 = 1'b1;
                steps_d  = steps_q + CNT_W'(1);
                state_d  = CHECK;
            end
            CHECK: begin
                // s0 only moves on odd steps, so after an odd step the copies can coincide
                // trivially; a genuine tortoise/hare meet is only counted after even steps.
                if ((s0_vec == s1_vec) && !steps_q[0]) begin
                    res_d.state = s0_vec;
                    res_d.steps = steps_q;
                    per_d       = '0;
                    state_d     = PSTEP;
                end else if (steps_q >= max_q) begin
                    res_d.timeout = 1'b1;
                    res_d.steps   = steps_q;
                    state_d       = OUT;
                end else begin
                    state_d = STEP;
                end
            end
            PSTEP: begin
                start_s1 = 1'b1;
                per_d    = per_q + CNT_W'(1);
                state_d  = PCHECK;
            end
            PCHECK: begin
                if (s1_vec == res_q.state) begin
                    res_d.period = per_q;
                    state_d      = OUT;
                end else if (per_q >= max_q) begin
                    res_d.timeout = 1'b1;
                    res_d.period  = '0;
                    state_d       = OUT;
                end else begin
                    state_d = PSTEP;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    cur_d  = cur_q + N_NODES'(1);
                    left_d = left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res_init    = res_q.init;
    assign res_state   = res_q.state;
    assign res_period  = res_q.period;
    assign res_steps   = res_q.steps;
    assign res_timeout = res_q.timeout;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a behavioural 4-node table-lookup node bank.
module tb_gnr_attractor_ctrl;

    localparam int N = 4;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] init_base = '0;
    logic [C-1:0] num_inits = '0;
    logic [C-1:0] max_steps = '0;
    logic         reset_nos, start_s0, start_s1;
    logic [N-1:0] init_state, s0_vec, s1_vec;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_init, res_state;
    logic [C-1:0] res_period, res_steps;
    logic         res_timeout, busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .start(start), .init_base(init_base),
        .num_inits(num_inits), .max_steps(max_steps), .reset_nos(reset_nos),
        .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
        .s0_vec(s0_vec), .s1_vec(s1_vec), .res_valid(res_valid), .res_ready(res_ready),
        .res_init(res_init), .res_state(res_state), .res_period(res_period),
        .res_steps(res_steps), .res_timeout(res_timeout), .busy(busy), .done(done)
    );

    // Node bank: s1 advances on every start, s0 only on every other start (pass bit).
    logic [N-1:0] lut [16];
    logic [N-1:0] s0_q = '0, s1_q = '0;
    logic         pass_q = 1'b0;

    always @(posedge clk) begin
        if (reset_nos) begin
            s0_q   <= init_state;
            s1_q   <= init_state;
            pass_q <= 1'b0;
        end else begin
            if (start_s1) s1_q <= lut[s1_q];
            if (start_s0) begin
                if (!pass_q) s0_q <= lut[s0_q];
                pass_q <= ~pass_q;
            end
        end
    end
    assign s0_vec = s0_q;
    assign s1_vec = s1_q;

    // Protocol monitor: node load/advance exclusivity and valid held until ready.
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            checks++;
            if (reset_nos && (start_s0 || start_s1)) begin
                failures++;
                $display("FAIL excl: reset_nos=%0b start_s0=%0b start_s1=%0b", reset_nos, start_s0, start_s1);
            end
            checks++;
            if (prev_valid && !prev_ready && !res_valid) begin
                failures++;
                $display("FAIL valid_drop: res_valid=0 required 1 (no handshake)");
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
        end
    end

    function automatic void lut_identity();
        for (int i = 0; i < 16; i++) lut[i] = N'(i);
    endfunction

    function automatic void lut_cycle();
        lut_identity();
        lut[0] = 4'd1; lut[1] = 4'd2; lut[2] = 4'd3; lut[3] = 4'd1;
    endfunction

    task automatic do_start(input logic [N-1:0] ib, input logic [C-1:0] ni, input logic [C-1:0] ms);
        @(negedge clk);
        init_base = ib; num_inits = ni; max_steps = ms; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [4*N+2*C+8:0] all_out;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        all_out = {reset_nos, start_s0, start_s1, init_state, res_valid, res_init, res_state,
                   res_period, res_steps, res_timeout, busy, done};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%0b required 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_fixed_point();
        bit ok;
        lut_identity();
        do_start(4'd5, 16'd1, 16'd20);
        wait_valid(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL fp_valid: no res_valid within budget"); end
        checks++;
        if ({res_init, res_state, res_period, res_steps, res_timeout} !== {4'd5, 4'd5, 16'd1, 16'd2, 1'b0}) begin
            failures++;
            $display("FAIL fp_result: init=%0d state=%0d period=%0d steps=%0d to=%0b required 5 5 1 2 0",
                     res_init, res_state, res_period, res_steps, res_timeout);
        end
        accept();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fp_done: done=%0b busy=%0b required 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL fp_done_pulse: done=%0b required 0", done); end
        $display("test_fixed_point init=5 state=%0d period=%0d steps=%0d", res_state, res_period, res_steps);
    endtask

    task automatic test_cycle();
        bit ok;
        lut_cycle();
        do_start(4'd0, 16'd1, 16'd20);
        wait_valid(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL cyc_valid: no res_valid within budget"); end
        checks++;
        if (res_period !== 16'd3 || res_timeout !== 1'b0 || res_steps !== 16'd6) begin
            failures++;
            $display("FAIL cyc_result: period=%0d to=%0b steps=%0d required 3 0 6", res_period, res_timeout, res_steps);
        end
        checks++;
        if (res_state < 4'd1 || res_state > 4'd3) begin
            failures++;
            $display("FAIL cyc_state: state=%0d required in 1..3", res_state);
        end
        $display("test_cycle init=0 state=%0d period=%0d steps=%0d", res_state, res_period, res_steps);
        accept();
    endtask

    task automatic test_timeout(input logic [C-1:0] ms, input logic [C-1:0] exp_steps);
        bit ok;
        lut_cycle();
        do_start(4'd0, 16'd1, ms);
        wait_valid(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL to_valid: no res_valid within budget"); end
        checks++;
        if (res_timeout !== 1'b1 || res_period !== 16'd0 || res_steps !== exp_steps) begin
            failures++;
            $display("FAIL to_result max=%0d: to=%0b period=%0d steps=%0d required 1 0 %0d",
                     ms, res_timeout, res_period, res_steps, exp_steps);
        end
        $display("test_timeout max=%0d to=%0b steps=%0d", ms, res_timeout, res_steps);
        accept();
    endtask

    task automatic test_zero_inits();
        do_start(4'd3, 16'd0, 16'd5);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_inits: done=%0b busy=%0b required 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || reset_nos !== 1'b0) begin
            failures++;
            $display("FAIL zero_inits_after: done=%0b reset_nos=%0b required 0 0", done, reset_nos);
        end
        $display("test_zero_inits done_pulse seen");
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [2*N+2*C:0] snap;
        lut_cycle();
        do_start(4'd0, 16'd2, 16'd20);
        wait_valid(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_valid: no res_valid within budget"); end
        snap = {res_init, res_state, res_period, res_steps, res_timeout};
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            init_base = 4'd9; num_inits = 16'd5;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || reset_nos !== 1'b0 ||
                {res_init, res_state, res_period, res_steps, res_timeout} !== snap) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d: valid=%0b reset_nos=%0b res=%h required 1 0 %h",
                         i, res_valid, reset_nos, {res_init, res_state, res_period, res_steps, res_timeout}, snap);
            end
        end
        start = 1'b0;
        accept();
        checks++;
        if (reset_nos !== 1'b1 || init_state !== 4'd1) begin
            failures++;
            $display("FAIL bp_load: reset_nos=%0b init_state=%0d required 1 1", reset_nos, init_state);
        end
        wait_valid(100, ok);
        checks++;
        if (!ok || res_init !== 4'd1 || res_period !== 16'd3 || res_state !== 4'd1 || res_steps !== 16'd6) begin
            failures++;
            $display("FAIL bp_second: ok=%0b init=%0d period=%0d state=%0d steps=%0d required 1 1 3 1 6",
                     ok, res_init, res_period, res_state, res_steps);
        end
        accept();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL bp_done: done=%0b required 1", done); end
        $display("test_backpressure second init=%0d period=%0d", res_init, res_period);
    endtask

    task automatic test_sweep();
        logic [N-1:0] got_init [4];
        logic [N-1:0] got_state [4];
        logic [N-1:0] exp_init [3];
        int n_res = 0;
        int n_done = 0;
        exp_init[0] = 4'd15; exp_init[1] = 4'd0; exp_init[2] = 4'd1;
        lut_identity();
        res_ready = 1'b1;
        do_start(4'd15, 16'd3, 16'd20);
        for (int i = 0; i < 80; i++) begin
            if (res_valid && n_res < 4) begin
                got_init[n_res] = res_init;
                got_state[n_res] = res_state;
                n_res++;
            end
            if (done) n_done++;
            @(negedge clk);
        end
        res_ready = 1'b0;
        checks++;
        if (n_res !== 3 || n_done !== 1) begin
            failures++;
            $display("FAIL sweep_count: results=%0d dones=%0d required 3 1", n_res, n_done);
        end
        for (int k = 0; k < 3 && k < n_res; k++) begin
            checks++;
            if (got_init[k] !== exp_init[k] || got_state[k] !== exp_init[k]) begin
                failures++;
                $display("FAIL sweep_res%0d: init=%0d state=%0d required %0d %0d",
                         k, got_init[k], got_state[k], exp_init[k], exp_init[k]);
            end
            $display("test_sweep result %0d init=%0d state=%0d", k, got_init[k], got_state[k]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found = 1'b0;
        logic [4*N+2*C+8:0] all_out;
        lut_cycle();
        do_start(4'd0, 16'd1, 16'd20);
        for (int i = 0; i < 60; i++) begin
            if (start_s1 && !start_s0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rm_pstep: PSTEP not reached"); end
        #2 rst = 1'b1;
        #1;
        all_out = {reset_nos, start_s0, start_s1, init_state, res_valid, res_init, res_state,
                   res_period, res_steps, res_timeout, busy, done};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL rm_outputs: got %h required 0", all_out);
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(4'd0, 16'd1, 16'd20);
        wait_valid(100, ok);
        checks++;
        if (!ok || res_period !== 16'd3 || res_state !== 4'd3 || res_steps !== 16'd6 || res_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rm_rerun: ok=%0b period=%0d state=%0d steps=%0d to=%0b required 1 3 3 6 0",
                     ok, res_period, res_state, res_steps, res_timeout);
        end
        $display("test_reset_mid rerun period=%0d state=%0d", res_period, res_state);
        accept();
    endtask

    initial begin
        lut_identity();
        test_reset();
        test_fixed_point();
        test_cycle();
        test_timeout(16'd2, 16'd2);
        test_timeout(16'd0, 16'd1);
        test_zero_inits();
        test_backpressure();
        test_sweep();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
